gtb_event_stamper: RTL and testbench



---
 rtl/gtb_event_stamper_if.sv | 32 +++
 rtl/gtb_event_stamper.sv | 159 +++++++++++++++
 tb/tb_gtb_event_stamper.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtb_event_stamper_if.sv
// rtl/gtb_event_stamper_if.sv - timestamp read-port interface for gtb_event_stamper
//
// Purpose: carries the first-word-fall-through read port of the event stamper.
// Ports (signals):
//   ts_valid  head entry present              (master -> slave)
//   ts_time   64-bit timestamp of head entry  (master -> slave)
//   ts_mask   N_EVT channel mask of head      (master -> slave)
//   ts_ready  consumer accepts head entry     (slave  -> master)
// N_EVT must match the N_EVT of the stamper it is connected to.

interface gtb_event_stamper_if #(
    parameter int N_EVT = 4
);
    logic             ts_valid;
    logic             ts_ready;
    logic [63:0]      ts_time;
    logic [N_EVT-1:0] ts_mask;

    modport master (
        output ts_valid,
        output ts_time,
        output ts_mask,
        input  ts_ready
    );

    modport slave (
        input  ts_valid,
        input  ts_time,
        input  ts_mask,
        output ts_ready
    );
endinterface

// File: rtl/gtb_event_stamper.sv
// rtl/gtb_event_stamper.sv - rising-edge event timestamper with FWFT queue
//
// Purpose: synchronizes N_EVT asynchronous event lines, detects rising edges,
// tags each edge set with the GTB time count and queues it in a FWFT FIFO.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   time_cnt     64-bit GTB time count (clk domain)
//   evt_in       asynchronous event lines
//   enable       gates edge detection (sync chains keep running)
//   clear_ovf    pulse: clears ovf_cnt / ovf_flag
//   ts_if        read port (ts_valid/ts_ready/ts_time/ts_mask), master side
//   fifo_count   occupancy 0..FIFO_DEPTH
//   ovf_flag     sticky drop indicator
//   ovf_cnt      saturating dropped-entry count

module gtb_event_stamper #(
    parameter int N_EVT       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 time_cnt,
    input  logic [N_EVT-1:0]            evt_in,
    input  logic                        enable,
    input  logic                        clear_ovf,
    gtb_event_stamper_if.master         ts_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        ovf_flag,
    output logic [15:0]                 ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 64 + N_EVT;
    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

    logic [N_EVT-1:0] sync_q [SYNC_STAGES];
    logic [N_EVT-1:0] sync_d [SYNC_STAGES];
    logic [N_EVT-1:0] prev_q, prev_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             armed_q, armed_d;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];

    logic             ts_valid_q, ts_valid_d;
    logic [63:0]      ts_time_q, ts_time_d;
    logic [N_EVT-1:0] ts_mask_q, ts_mask_d;

    logic             ovf_flag_q, ovf_flag_d;
    logic [15:0]      ovf_cnt_q, ovf_cnt_d;

    logic [N_EVT-1:0] rise;
    logic             push, pop, full, accept, drop;
    logic [EW-1:0]    head_d;

    always_comb begin
        sync_d[0] = evt_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];

        // Arming covers the window in which a line held high through reset
        // release would otherwise look like a fresh edge.
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            arm_cnt_d = arm_cnt_q + 3'd1;
            if (arm_cnt_q == ARM_LAST) begin
                armed_d = 1'b1;
            end
        end

        rise = sync_q[SYNC_STAGES-1] & ~prev_q & {N_EVT{enable & armed_q}};
        push = |rise;
        pop  = ts_valid_q & ts_if.ts_ready;
        full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        accept = push & (~full | pop);
        drop   = push & full & ~pop;

        mem_d = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q[AW-1:0]] = {time_cnt, rise};
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        // Head register is loaded from the post-write memory image so an entry
        // written into an empty FIFO is presented on the very next cycle.
        head_d     = mem_d[rd_ptr_d[AW-1:0]];
        ts_valid_d = (wr_ptr_d != rd_ptr_d);
        ts_time_d  = ts_valid_d ? head_d[EW-1:N_EVT] : 64'd0;
        ts_mask_d  = ts_valid_d ? head_d[N_EVT-1:0]  : '0;

        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (drop) begin
            ovf_flag_d = 1'b1;
            if (clear_ovf) begin
                ovf_cnt_d = 16'd1;
            end else if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end else if (clear_ovf) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q     <= '0;
            arm_cnt_q  <= 3'd0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ts_valid_q <= 1'b0;
            ts_time_q  <= 64'd0;
            ts_mask_q  <= '0;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= 16'd0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q     <= prev_d;
            arm_cnt_q  <= arm_cnt_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ts_valid_q <= ts_valid_d;
            ts_time_q  <= ts_time_d;
            ts_mask_q  <= ts_mask_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ts_if.ts_valid = ts_valid_q;
    assign ts_if.ts_time  = ts_time_q;
    assign ts_if.ts_mask  = ts_mask_q;
    assign fifo_count     = wr_ptr_q - rd_ptr_q;
    assign ovf_flag       = ovf_flag_q;
    assign ovf_cnt        = ovf_cnt_q;

endmodule

// File: tb/tb_gtb_event_stamper.sv
// tb/tb_gtb_event_stamper.sv - directed self-checking bench for gtb_event_stamper

module tb_gtb_event_stamper;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] time_cnt;
    logic [3:0]  evt_in;
    logic        enable;
    logic        clear_ovf;
    logic [4:0]  fifo_count;
    logic        ovf_flag;
    logic [15:0] ovf_cnt;

    int checks   = 0;
    int failures = 0;

    logic [67:0] exp_q [$];
    logic [63:0] t0;

    gtb_event_stamper_if #(.N_EVT(4)) ts_if ();

    gtb_event_stamper #(
        .N_EVT(4),
        .FIFO_DEPTH(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .time_cnt(time_cnt),
        .evt_in(evt_in),
        .enable(enable),
        .clear_ovf(clear_ovf),
        .ts_if(ts_if),
        .fifo_count(fifo_count),
        .ovf_flag(ovf_flag),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // GTB stand-in: counts from 0x100 after reset.
    always @(posedge clk) begin
        if (reset) time_cnt <= 64'h100;
        else       time_cnt <= time_cnt + 64'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Two-cycle pulse on mask m; the stamp is the count two edges after the
    // first sampling edge. Optionally pops the head in the write cycle.
    task automatic pulse(input logic [3:0] m, input bit pop_at_write);
        logic [63:0] t;
        @(negedge clk);
        t = time_cnt;
        evt_in = m;
        @(negedge clk);
        @(negedge clk);
        evt_in = 4'b0000;
        if (pop_at_write) begin
            check("fpp_head_time", ts_if.ts_time, exp_q[0][67:4]);
            ts_if.ts_ready = 1'b1;
        end
        @(negedge clk);
        ts_if.ts_ready = 1'b0;
        if (pop_at_write) begin
            void'(exp_q.pop_front());
            exp_q.push_back({t + 64'd2, m});
        end else if (exp_q.size() < 16) begin
            exp_q.push_back({t + 64'd2, m});
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n, input string tag);
        logic [67:0] e;
        logic [63:0] last;
        last = 64'd0;
        ts_if.ts_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra_valid"}, ts_if.ts_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_valid"}, ts_if.ts_valid, 1);
                check({tag, "_time"}, ts_if.ts_time, e[67:4]);
                check({tag, "_mask"}, ts_if.ts_mask, e[3:0]);
                if (i > 0) check({tag, "_incr"}, ts_if.ts_time > last, 1);
                last = ts_if.ts_time;
            end
            @(negedge clk);
        end
        ts_if.ts_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        evt_in = 4'b0100;
        enable = 1'b1;
        clear_ovf = 1'b0;
        ts_if.ts_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", ts_if.ts_valid, 0);
        check("rst_time", ts_if.ts_time, 0);
        check("rst_mask", ts_if.ts_mask, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf_flag", ovf_flag, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);

        // evt_in[2] held high through reset release
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("arm_hold_count", fifo_count, 0);
        check("arm_hold_valid", ts_if.ts_valid, 0);
        evt_in = 4'b0000;
        repeat (4) @(negedge clk);
        check("fall_no_entry", fifo_count, 0);

        // single event latency
        t0 = time_cnt;
        evt_in = 4'b0010;
        @(negedge clk);
        check("lat_e0_valid", ts_if.ts_valid, 0);
        @(negedge clk);
        check("lat_e1_valid", ts_if.ts_valid, 0);
        @(negedge clk);
        check("lat_e2_valid", ts_if.ts_valid, 1);
        check("single_time", ts_if.ts_time, t0 + 64'd2);
        check("single_mask", ts_if.ts_mask, 4'b0010);
        check("single_count", fifo_count, 1);
        evt_in = 4'b0000;
        @(negedge clk);
        check("single_hold_time", ts_if.ts_time, t0 + 64'd2);
        ts_if.ts_ready = 1'b1;
        @(negedge clk);
        ts_if.ts_ready = 1'b0;
        check("single_pop_count", fifo_count, 0);
        check("single_pop_valid", ts_if.ts_valid, 0);
        repeat (3) @(negedge clk);

        // simultaneous edges
        pulse(4'b1001, 1'b0);
        check("simul_count", fifo_count, 1);
        drain(1, "simul");

        // overflow
        for (int i = 0; i < 20; i++) pulse(4'(1 << (i % 4)), 1'b0);
        check("ovf_count", fifo_count, 16);
        check("ovf_cnt", ovf_cnt, 4);
        check("ovf_flag", ovf_flag, 1);
        drain(16, "ovf");
        check("ovf_drained", fifo_count, 0);
        check("ovf_cnt_held", ovf_cnt, 4);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("clr_ovf_cnt", ovf_cnt, 0);
        check("clr_ovf_flag", ovf_flag, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) pulse(4'b0001, 1'b0);
        check("fpp_full", fifo_count, 16);
        pulse(4'b1000, 1'b1);
        check("fpp_count", fifo_count, 16);
        check("fpp_ovf_cnt", ovf_cnt, 0);
        check("fpp_ovf_flag", ovf_flag, 0);
        drain(16, "fpp");
        check("fpp_empty", fifo_count, 0);

        // enable gating: line rises while disabled, still high on re-enable
        enable = 1'b0;
        evt_in = 4'b0001;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("en_no_entry", fifo_count, 0);
        evt_in = 4'b0000;
        repeat (3) @(negedge clk);
        pulse(4'b0001, 1'b0);
        check("en_entry_count", fifo_count, 1);
        drain(1, "en");

        // reset mid-operation with 5 queued and two drops
        for (int i = 0; i < 18; i++) pulse(4'(1 << (i % 4)), 1'b0);
        ts_if.ts_ready = 1'b1;
        repeat (11) @(negedge clk);
        ts_if.ts_ready = 1'b0;
        check("mid_count", fifo_count, 5);
        check("mid_ovf_cnt", ovf_cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", ts_if.ts_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ovf_cnt", ovf_cnt, 0);
        check("mid_rst_ovf_flag", ovf_flag, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);

        // pointer wrap: 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            pulse(4'(i % 15 + 1), 1'b0);
            drain(1, "wrap");
        end
        check("wrap_empty", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
